// File: rtl/led_pkg.sv
// led_pkg: shared LED mode codes, debounce FSM encoding and counter width
package led_pkg;
  localparam logic [1:0] MODE_SIDES   = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_CHASE   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;
  localparam int DEB_CNT_W = 24;
  typedef enum logic [1:0] {INIT, IDLE, SETTLE} deb_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // first flop may go metastable; second gives it a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: debounces a 2-bit switch pair as one value into a registered LED mode
module switch_debounce
  import led_pkg::*;
#(
  parameter int CLK_HZ          = 125_000_000,
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] switch,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       mode_change
);
  localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << DEB_CNT_W) - 1 || CLK_HZ < 1) begin : g_bad_param
    $error("switch_debounce: DEBOUNCE_CYCLES out of range 2..2^24-1");
  end
  logic [1:0] sw_s;
  for (genvar i = 0; i < 2; i++) begin : g_sync
    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(switch[i]), .q(sw_s[i]));
  end
  deb_state_t state_q, state_d;
  logic [1:0] cand_q, cand_d, mode_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic valid_d, change_d;
  // all state and outputs are registers; outputs never depend combinationally on inputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= INIT;
      cand_q      <= '0;
      cnt_q       <= '0;
      mode        <= MODE_SIDES;
      mode_valid  <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      mode        <= mode_d;
      mode_valid  <= valid_d;
      mode_change <= change_d;
    end
  // any move of the pair restarts the window, so both bits settle together
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    mode_d   = mode;
    valid_d  = mode_valid;
    change_d = 1'b0;
    case (state_q)
      INIT:
        if (sw_s != cand_q) begin
          cand_d = sw_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          mode_d  = cand_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      IDLE:
        if (sw_s != mode) begin
          cand_d  = sw_s;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      SETTLE:
        if (sw_s != cand_q) begin
          cand_d = sw_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          mode_d   = cand_q;
          change_d = cand_q != mode;
          state_d  = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = INIT;
    endcase
  end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed and random checks of switch_debounce against a run-length model
module tb_switch_debounce;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] switch = 2'b00;
  logic [1:0] mode;
  logic mode_valid, mode_change;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int n01 = 0;
  logic prev_chg = 1'b0;
  logic [1:0] d1, d2, prev, sws, m_mode;
  logic m_valid, m_chg;
  int run;

  switch_debounce #(.CLK_HZ(125_000_000), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch),
    .mode(mode), .mode_valid(mode_valid), .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Model: the synchronized pair is the raw pin seen two samples late; a value is
  // accepted once it has been sampled N+1 times in a row (reset counts as one sample of 00).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 2'b00; d2 = 2'b00; prev = 2'b00; run = 1;
      m_mode = 2'b00; m_valid = 1'b0; m_chg = 1'b0;
    end else begin
      sws = d2; d2 = d1; d1 = switch;
      run = (sws == prev) ? ((run > N + 1) ? run : run + 1) : 1;
      prev = sws;
      m_chg = 1'b0;
      if (run == N + 1) begin
        if (!m_valid) begin m_mode = sws; m_valid = 1'b1; end
        else if (sws != m_mode) begin m_mode = sws; m_chg = 1'b1; end
      end
    end
  end

  // compare every cycle, away from the rising edge
  always @(negedge clk) begin
    check("outputs{mode,valid,change}", {29'd0, mode, mode_valid, mode_change}, {29'd0, m_mode, m_valid, m_chg});
    if (mode_change) begin
      pulses++;
      check("change_needs_valid", {31'd0, mode_valid}, 32'd1);
      check("change_not_back_to_back", {31'd0, prev_chg}, 32'd0);
    end
    if (mode == 2'b01) n01++;
    prev_chg = mode_change;
  end

  task automatic do_reset(input logic [1:0] sw);
    @(negedge clk);
    #2 rst_n = 1'b0;
    switch = sw;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int c);
    c = 0;
    while (mode_valid !== 1'b1 && c < bound) begin @(negedge clk); c++; end
  endtask

  task automatic wait_mode(input logic [1:0] v, input int bound, output int c);
    c = 0;
    while (mode !== v && c < bound) begin @(negedge clk); c++; end
  endtask

  initial begin
    int c, p0, q0;
    // power-up with 10 held
    switch = 2'b10;
    repeat (3) @(negedge clk);
    check("reset_mode", {30'd0, mode}, 32'd0);
    check("reset_valid", {31'd0, mode_valid}, 32'd0);
    check("reset_change", {31'd0, mode_change}, 32'd0);
    p0 = pulses;
    rst_n = 1'b1;
    wait_valid(30, c);
    check_range("powerup_latency", c, 16, 20);
    check("powerup_mode", {30'd0, mode}, 32'd2);
    repeat (5) @(negedge clk);
    check("powerup_pulses", pulses - p0, 0);
    // clean change 00 -> 01
    do_reset(2'b00);
    wait_valid(30, c);
    p0 = pulses;
    switch = 2'b01;
    wait_mode(2'b01, 30, c);
    check_range("clean_latency", c, 16, 20);
    repeat (10) @(negedge clk);
    check("clean_pulses", pulses - p0, 1);
    // glitch to 11 for 10 cycles
    do_reset(2'b00);
    wait_valid(30, c);
    p0 = pulses;
    switch = 2'b11;
    repeat (10) @(negedge clk);
    switch = 2'b00;
    repeat (40) @(negedge clk);
    check("glitch_mode", {30'd0, mode}, 32'd0);
    check("glitch_pulses", pulses - p0, 0);
    // skewed flip
    do_reset(2'b00);
    wait_valid(30, c);
    p0 = pulses; q0 = n01;
    switch = 2'b01;
    repeat (8) @(negedge clk);
    switch = 2'b11;
    wait_mode(2'b11, 40, c);
    check_range("skew_latency_after_bit1", c, 16, 20);
    repeat (10) @(negedge clk);
    check("skew_mode", {30'd0, mode}, 32'd3);
    check("skew_pulses", pulses - p0, 1);
    check("skew_no_01", n01 - q0, 0);
    // bounce between 00 and 01
    do_reset(2'b00);
    wait_valid(30, c);
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      switch = (i % 2 == 0) ? 2'b01 : 2'b00;
      repeat (5) @(negedge clk);
    end
    switch = 2'b01;
    wait_mode(2'b01, 30, c);
    check_range("bounce_latency", c, 16, 20);
    repeat (10) @(negedge clk);
    check("bounce_pulses", pulses - p0, 1);
    // reset twelve cycles into a 00 -> 11 settle
    do_reset(2'b00);
    wait_valid(30, c);
    switch = 2'b11;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_mode", {30'd0, mode}, 32'd0);
    check("midreset_valid", {31'd0, mode_valid}, 32'd0);
    repeat (3) @(negedge clk);
    p0 = pulses;
    rst_n = 1'b1;
    wait_valid(30, c);
    check_range("midreset_latency", c, 16, 20);
    check("midreset_new_mode", {30'd0, mode}, 32'd3);
    repeat (5) @(negedge clk);
    check("midreset_pulses", pulses - p0, 0);
    // random holds and occasional resets, checked by the model each cycle
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) do_reset(2'($urandom_range(0, 3)));
      else begin
        switch = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
